// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection stage: channel and flow-control
// field offsets, the injector FSM state type and VC index width helper.
package noc_pkg;

    localparam int CH_VALID_OFF = 0;
    localparam int CH_HEAD_OFF  = 1;
    localparam int CH_TAIL_OFF  = 2;
    localparam int CH_VC_OFF    = 3;

    localparam int FC_VALID_OFF = 0;
    localparam int FC_VC_OFF    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } inj_state_t;

    function automatic int vc_idx_width(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    // Data payload follows the three framing bits and the VC field.
    function automatic int ch_data_off(input int vc_w);
        return CH_VC_OFF + vc_w;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit counter for a single virtual channel; flags a
// credit return that would exceed the buffer depth.
module credit_counter
    import noc_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int RESET_VAL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             consume,
    input  logic             ret,
    input  logic [CNT_W-1:0] depth,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    // A simultaneous consume frees a slot, so a return at full depth is legal then.
    assign overflow = ret && !consume && (count == depth);
    assign nonzero  = (count != '0);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_W'(RESET_VAL);
        end else begin
            case ({consume, ret})
                2'b10:   count <= count - CNT_W'(1);
                2'b01:   if (!overflow) count <= count + CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flit_injector.sv
// Network-interface injection stage: frames host flits, locks a VC per packet,
// enforces per-VC credits and drives a registered router input channel.
module flit_injector
    import noc_pkg::*;
#(
    parameter int  NUM_VCS         = 4,
    parameter int  FLIT_DATA_WIDTH = 336,
    parameter int  FLOW_CTRL_WIDTH = 11,
    parameter int  BUFFER_DEPTH    = 8,
    localparam int VC_IDX_W        = vc_idx_width(NUM_VCS),
    localparam int CHANNEL_WIDTH   = 3 + VC_IDX_W + FLIT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_head,
    input  logic                       in_tail,
    input  logic [VC_IDX_W-1:0]        in_vc,
    input  logic [FLIT_DATA_WIDTH-1:0] in_data,
    output logic [0:CHANNEL_WIDTH-1]   channel_out,
    input  logic [0:FLOW_CTRL_WIDTH-1] flow_ctrl_in,
    output logic                       error
);

    localparam int CNT_W       = $clog2(BUFFER_DEPTH + 1);
    localparam int CH_DATA_OFF = ch_data_off(VC_IDX_W);

    inj_state_t                state, state_d;
    logic [VC_IDX_W-1:0]       cur_vc, cur_vc_d, target_vc;
    logic                      frame_err, accept, forward;
    logic [NUM_VCS-1:0]        consume, ret, nonzero, overflow;
    logic [CNT_W-1:0]          credit [NUM_VCS];
    logic [0:CHANNEL_WIDTH-1]  chan_d;

    logic                      fc_valid;
    logic [VC_IDX_W-1:0]       fc_vc;
    logic                      unused_fc;

    assign fc_valid  = flow_ctrl_in[FC_VALID_OFF];
    assign fc_vc     = flow_ctrl_in[FC_VC_OFF +: VC_IDX_W];
    assign unused_fc = ^flow_ctrl_in[FC_VC_OFF+VC_IDX_W : FLOW_CTRL_WIDTH-1];

    // Misframed flits are always accepted so the host can never deadlock on them.
    always_comb begin
        target_vc = (state == ST_IDLE) ? in_vc : cur_vc;
        frame_err = (state == ST_IDLE) ? !in_head : in_head;
        in_ready  = frame_err | nonzero[target_vc];
        accept    = in_valid & in_ready;
        forward   = accept & !frame_err;
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            consume[v] = forward && (target_vc == VC_IDX_W'(v));
            ret[v]     = fc_valid && (fc_vc == VC_IDX_W'(v));
        end
    end

    // NOTE: every signal written here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        cur_vc_d = cur_vc;
        if (forward) begin
            case (state)
                ST_IDLE: begin
                    cur_vc_d = in_vc;
                    if (!in_tail) state_d = ST_BODY;
                end
                ST_BODY: if (in_tail) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        chan_d = '0;
        if (forward) begin
            chan_d[CH_VALID_OFF]                   = 1'b1;
            chan_d[CH_HEAD_OFF]                    = in_head;
            chan_d[CH_TAIL_OFF]                    = in_tail;
            chan_d[CH_VC_OFF +: VC_IDX_W]          = target_vc;
            chan_d[CH_DATA_OFF +: FLIT_DATA_WIDTH] = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_vc      <= '0;
            channel_out <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_d;
            cur_vc      <= cur_vc_d;
            channel_out <= chan_d;
            error       <= error | (accept & frame_err) | (|overflow);
        end
    end

    for (genvar v = 0; v < NUM_VCS; v++) begin : gen_vc
        credit_counter #(
            .CNT_W     (CNT_W),
            .RESET_VAL (BUFFER_DEPTH)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .consume  (consume[v]),
            .ret      (ret[v]),
            .depth    (CNT_W'(BUFFER_DEPTH)),
            .count    (credit[v]),
            .nonzero  (nonzero[v]),
            .overflow (overflow[v])
        );
    end

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: framing, credit flow, overflow, violations
// and asynchronous reset, with hand-computed expectations.
module tb_flit_injector;
    import noc_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_head;
    logic         in_tail;
    logic [1:0]   in_vc;
    logic [335:0] in_data;
    logic [0:340] channel_out;
    logic [0:10]  flow_ctrl_in;
    logic         error;

    int checks = 0;
    int errors = 0;

    flit_injector dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_head      (in_head),
        .in_tail      (in_tail),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .channel_out  (channel_out),
        .flow_ctrl_in (flow_ctrl_in),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_head      = 1'b0;
        in_tail      = 1'b0;
        in_vc        = 2'd0;
        in_data      = '0;
        flow_ctrl_in = '0;
    endtask

    task automatic send_credit(input logic [1:0] vc);
        flow_ctrl_in      = '0;
        flow_ctrl_in[0]   = 1'b1;
        flow_ctrl_in[1:2] = vc;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (channel_out !== '0) begin
            errors++; $display("FAIL reset_channel: got %0h want 0", channel_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b want 0", error);
        end
        checks++;
        if (dut.state !== ST_IDLE || dut.cur_vc !== 2'd0) begin
            errors++; $display("FAIL reset_fsm: state %0d cur_vc %0d want 0 0", dut.state, dut.cur_vc);
        end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dut.credit[v] !== 4'd8) begin
                errors++; $display("FAIL reset_credit%0d: got %0d want 8", v, dut.credit[v]);
            end
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_flit();
        logic [0:340] exp_ch;
        do_reset();
        in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_vc = 2'd2; in_data = 336'hA5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b want 1", in_ready);
        end
        tick();
        idle_inputs();
        exp_ch = '0;
        exp_ch[0] = 1'b1; exp_ch[1] = 1'b1; exp_ch[2] = 1'b1;
        exp_ch[3:4] = 2'd2;
        exp_ch[5:340] = 336'hA5;
        checks++;
        if (channel_out !== exp_ch) begin
            errors++; $display("FAIL single_channel: got %0h want %0h", channel_out, exp_ch);
        end
        checks++;
        if (dut.credit[2] !== 4'd7) begin
            errors++; $display("FAIL single_credit2: got %0d want 7", dut.credit[2]);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++; $display("FAIL single_state: got %0d want IDLE", dut.state);
        end
        tick();
        checks++;
        if (channel_out !== '0) begin
            errors++; $display("FAIL single_bubble: got %0h want 0", channel_out);
        end
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_head = (i == 0); in_tail = 1'b0;
            in_vc    = (i == 0) ? 2'd1 : 2'd3;
            in_data  = 336'(i + 16);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL exhaust_ready%0d: got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (channel_out[0] !== 1'b1 || channel_out[3:4] !== 2'd1 ||
                channel_out[5:340] !== 336'(i + 16)) begin
                errors++; $display("FAIL exhaust_flit%0d: valid %b vc %0d data %0h want 1 1 %0h",
                                   i, channel_out[0], channel_out[3:4], channel_out[5:340], i + 16);
            end
        end
        checks++;
        if (dut.credit[1] !== 4'd0) begin
            errors++; $display("FAIL exhaust_credit: got %0d want 0", dut.credit[1]);
        end
        in_head = 1'b0; in_data = 336'h99;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL exhaust_stall: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (channel_out[0] !== 1'b0 || dut.state !== ST_BODY) begin
            errors++; $display("FAIL exhaust_hold: valid %b state %0d want 0 BODY", channel_out[0], dut.state);
        end
        send_credit(2'd1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL credit_same_cycle: got %b want 0", in_ready);
        end
        tick();
        flow_ctrl_in = '0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL credit_next_cycle: got %b want 1", in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (channel_out[0] !== 1'b1 || channel_out[5:340] !== 336'h99) begin
            errors++; $display("FAIL exhaust_ninth: valid %b data %0h want 1 99", channel_out[0], channel_out[5:340]);
        end
        checks++;
        if (error !== 1'b0 || dut.credit[1] !== 4'd0) begin
            errors++; $display("FAIL exhaust_final: error %b credit %0d want 0 0", error, dut.credit[1]);
        end
    endtask

    task automatic test_consume_and_return();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_head = (i == 0); in_tail = 1'b0; in_vc = 2'd0; in_data = 336'(i);
            tick();
        end
        checks++;
        if (dut.credit[0] !== 4'd3) begin
            errors++; $display("FAIL cr_setup: got %0d want 3", dut.credit[0]);
        end
        in_head = 1'b0; in_data = 336'h77;
        send_credit(2'd0);
        tick();
        idle_inputs();
        checks++;
        if (dut.credit[0] !== 4'd3 || channel_out[0] !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL cr_net: credit %0d valid %b error %b want 3 1 0",
                               dut.credit[0], channel_out[0], error);
        end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        send_credit(2'd3);
        tick();
        flow_ctrl_in = '0;
        checks++;
        if (error !== 1'b1 || dut.credit[3] !== 4'd8) begin
            errors++; $display("FAIL ovf_set: error %b credit %0d want 1 8", error, dut.credit[3]);
        end
        tick(); tick(); tick();
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b want 1", error);
        end
        do_reset();
        in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_vc = 2'd3; in_data = 336'h5;
        send_credit(2'd3);
        tick();
        idle_inputs();
        checks++;
        if (error !== 1'b0 || dut.credit[3] !== 4'd8 || channel_out[0] !== 1'b1) begin
            errors++; $display("FAIL ovf_cancel: error %b credit %0d valid %b want 0 8 1",
                               error, dut.credit[3], channel_out[0]);
        end
    endtask

    task automatic test_framing();
        do_reset();
        in_valid = 1'b1; in_head = 1'b0; in_tail = 1'b0; in_vc = 2'd0; in_data = 336'h11;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL frame_idle_ready: got %b want 1", in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (channel_out[0] !== 1'b0 || error !== 1'b1 || dut.state !== ST_IDLE || dut.credit[0] !== 4'd8) begin
            errors++; $display("FAIL frame_idle: valid %b error %b state %0d credit %0d want 0 1 IDLE 8",
                               channel_out[0], error, dut.state, dut.credit[0]);
        end
        do_reset();
        in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b0; in_vc = 2'd1; in_data = 336'h22;
        tick();
        in_vc = 2'd2; in_data = 336'h33;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL frame_body_ready: got %b want 1", in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (channel_out[0] !== 1'b0 || error !== 1'b1) begin
            errors++; $display("FAIL frame_body: valid %b error %b want 0 1", channel_out[0], error);
        end
        checks++;
        if (dut.cur_vc !== 2'd1 || dut.state !== ST_BODY || dut.credit[1] !== 4'd7 || dut.credit[2] !== 4'd8) begin
            errors++; $display("FAIL frame_body_state: cur_vc %0d state %0d c1 %0d c2 %0d want 1 BODY 7 8",
                               dut.cur_vc, dut.state, dut.credit[1], dut.credit[2]);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_head = (i == 0); in_tail = 1'b0; in_vc = 2'd1; in_data = 336'(i + 1);
            tick();
        end
        in_data = 336'h4;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (channel_out !== '0 || dut.credit[1] !== 4'd8 || dut.state !== ST_IDLE) begin
            errors++; $display("FAIL midreset: channel %0h credit %0d state %0d want 0 8 IDLE",
                               channel_out, dut.credit[1], dut.state);
        end
        idle_inputs();
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_vc = 2'd0; in_data = 336'h3C;
        tick();
        idle_inputs();
        checks++;
        if (channel_out[0] !== 1'b1 || channel_out[3:4] !== 2'd0 || channel_out[5:340] !== 336'h3C ||
            dut.credit[0] !== 4'd7 || error !== 1'b0) begin
            errors++; $display("FAIL midreset_new: valid %b vc %0d data %0h credit %0d error %b want 1 0 3c 7 0",
                               channel_out[0], channel_out[3:4], channel_out[5:340], dut.credit[0], error);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_flit();
        test_credit_exhaustion();
        test_consume_and_return();
        test_credit_overflow();
        test_framing();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_injector.md
# flit_injector

Network-interface injection stage that sits directly upstream of a mesh router input port. It accepts a host flit stream with head/tail framing and locks a virtual channel per packet. It tracks per-VC downstream buffer credits returned on the router's flow-control output and drives the router's input channel with registered, credit-legal flits. It raises a sticky error on credit-protocol or framing violations.

## Interface
- NUM_VCS, 4, virtual channels; VC_IDX_W = clog2(NUM_VCS) = 2
- FLIT_DATA_WIDTH, 336, payload bits per flit
- CHANNEL_WIDTH, 341, = 3 + VC_IDX_W + FLIT_DATA_WIDTH
- FLOW_CTRL_WIDTH, 11, credit bus width
- BUFFER_DEPTH, 8, router input buffer entries per VC = initial credits
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high
- in_valid  in  1  host flit valid
- in_ready  out  1  host flit accepted when in_valid & in_ready
- in_head  in  1  first flit of packet
- in_tail  in  1  last flit of packet (head & tail = single-flit packet)
- in_vc  in  VC_IDX_W  target VC; sampled on head flits only
- in_data  in  FLIT_DATA_WIDTH  payload
- channel_out  out  [0:CHANNEL_WIDTH-1]  to router channel input; bit 0 valid, 1 head, 2 tail, [3:3+VC_IDX_W-1] vc, remainder data
- flow_ctrl_in  in  [0:FLOW_CTRL_WIDTH-1]  from router flow-control output; bit 0 credit valid, [1:VC_IDX_W] credit vc, rest ignored
- error  out  1  sticky violation flag

## Operation
- FSM, two states:
  - IDLE: expecting a head flit.
  - BODY: packet in progress; VC locked in cur_vc.
- IDLE, accepted head: latch in_vc into cur_vc. Go to BODY unless in_tail is set; a single-flit packet stays in IDLE.
- BODY, accepted non-head flit: uses cur_vc; in_vc is ignored. An accepted tail returns to IDLE.
- Target VC: in_vc in IDLE, cur_vc in BODY.
- in_ready = credit[target VC] != 0 for well-framed flits. It is combinational from registered state and in_vc.
- Framing violation: non-head flit in IDLE, or head flit in BODY.
  - in_ready is 1 regardless of credits.
  - The flit is consumed and discarded; FSM state is unchanged.
  - error is set.
- Credit counters: one per VC, width clog2(BUFFER_DEPTH+1). Each forwarded flit decrements its VC. A received credit (flow_ctrl_in bit 0) increments the credit vc.
- Same VC, same cycle consume and return: net unchanged.
- Credit return to a counter already at BUFFER_DEPTH: counter holds and error is set. A consume on that VC in the same cycle makes the return legal (net unchanged).
- Counters never go below 0; in_ready gating guarantees this.
- error clears only on reset.

## Timing
- Reset values:
  - channel_out all 0.
  - in_ready reflects credits = BUFFER_DEPTH, so it is 1 out of reset.
  - error 0; FSM IDLE; cur_vc 0; all credits BUFFER_DEPTH.
- Latency: a flit accepted in cycle t appears on channel_out in cycle t+1 with valid=1. If nothing is forwarded in t, channel_out has valid=0 and data fields 0 in t+1.
- Throughput: one flit per cycle while credits remain.
- Credit received in cycle t updates the counter at the t+1 edge. in_ready can use it from cycle t+1.
- An exhausted VC stalls the host (in_ready=0) without changing FSM state. Other VCs are only reachable at packet boundaries.
- Reset asserted mid-packet clears everything immediately. The partial packet is abandoned; the router owns any cleanup.

## Structure
- Shared package noc_pkg:
  - channel field offsets and widths.
  - flow-control field offsets.
  - FSM state enum.
  - function vc_idx_width(NUM_VCS).
- Sub-module credit_counter holds one VC's counter. Inputs: consume, ret, depth. Outputs: count, nonzero, overflow. Instantiated NUM_VCS times.
- The top holds the FSM, cur_vc, the output register and the error register.

## Test plan
- Reset then single-flit packet: head=tail=1, vc=2, data=0xA5. Required: channel_out next cycle has valid=1, head=1, tail=1, vc=2, data=0xA5; credit[2]=7; FSM IDLE.
- Credit exhaustion: 10-flit packet on vc=1, no credits returned. Required: 8 flits forwarded, in_ready=0 on the 9th. One credit for vc1 arrives; in_ready=1 the next cycle; the 9th flit forwards. error stays 0.
- Simultaneous consume and return on vc0 at count 3. Required: count stays 3.
- Credit overflow: credit for vc3 while credit[3]=8 and no consume. Required: error=1 and stays set; counter stays 8.
- Framing violation: body flit (head=0) in IDLE. Required: in_ready=1, nothing forwarded (valid=0), error=1. Also head in BODY. Required: discarded, error=1, cur_vc unchanged.
- Reset mid-packet after 3 of 5 flits on vc1. Required: channel_out=0 and credit[1]=8 immediately. A new head on vc0 is then accepted normally.
